// File: rtl/regfile_pkg.sv
// Shared helpers for the register bank: index width, byte count and byte-strobe merge.
package regfile_pkg;

  // Widest entry the merge helper handles; callers zero-extend into it and truncate the result.
  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;

  function automatic int idx_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0] old_v,
                                                input logic [MAX_W-1:0] new_v,
                                                input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MAX_B; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One bank entry: WIDTH-bit register with byte-strobe write and a written-since-reset flag.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              NB      = nbytes(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [NB-1:0]    be,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RST_VAL;
      vld <= 1'b0;
    end else if (we) begin
      q <= WIDTH'(merge_be(MAX_W'(q), MAX_W'(data), MAX_B'(be)));
      // An all-zero strobe writes nothing, so it must not mark the entry valid.
      if (|be) vld <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// Register bank: DEPTH entries, one byte-strobed write port, two registered read ports,
// optional same-cycle write forwarding and out-of-range index error pulses.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 4,
  parameter int               BYPASS  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              IW      = idx_w(DEPTH),
  localparam int              NB      = nbytes(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [IW-1:0]    rd_idx_a,
  input  logic             rd_en_b,
  input  logic [IW-1:0]    rd_idx_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_vld_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_vld_b,
  output logic             wr_err,
  output logic             rd_err
);

  generate
    if ((WIDTH % 8) != 0 || WIDTH > MAX_W || DEPTH < 2) begin : g_bad_param
      $error("regfile_bank: unsupported WIDTH/DEPTH");
    end
  endgenerate

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH);
  localparam bit          BYP     = (BYPASS != 0);

  logic [WIDTH-1:0] ent_q [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] wr_hit;

  logic wr_ok, ok_a, ok_b;
  logic hit_a, hit_b;
  logic [WIDTH-1:0] nxt_data_a, nxt_data_b;
  logic             nxt_vld_a, nxt_vld_b;

  assign wr_ok = wr_en && ({1'b0, wr_idx} < DEPTH_L);
  assign ok_a  = ({1'b0, rd_idx_a} < DEPTH_L);
  assign ok_b  = ({1'b0, rd_idx_b} < DEPTH_L);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign wr_hit[i] = wr_ok && (wr_idx == IW'(i));

      regfile_entry #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_ent (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_hit[i]),
        .be   (wr_be),
        .data (wr_data),
        .q    (ent_q[i]),
        .vld  (ent_vld[i])
      );
    end
  endgenerate

  // Out-of-range indices may select garbage here; the registered stage zeroes those reads.
  always_comb begin
    hit_a      = BYP && wr_ok && (wr_idx == rd_idx_a);
    hit_b      = BYP && wr_ok && (wr_idx == rd_idx_b);
    nxt_data_a = ent_q[rd_idx_a];
    nxt_vld_a  = ent_vld[rd_idx_a];
    nxt_data_b = ent_q[rd_idx_b];
    nxt_vld_b  = ent_vld[rd_idx_b];
    if (hit_a) begin
      nxt_data_a = WIDTH'(merge_be(MAX_W'(nxt_data_a), MAX_W'(wr_data), MAX_B'(wr_be)));
      nxt_vld_a  = nxt_vld_a | (|wr_be);
    end
    if (hit_b) begin
      nxt_data_b = WIDTH'(merge_be(MAX_W'(nxt_data_b), MAX_W'(wr_data), MAX_B'(wr_be)));
      nxt_vld_b  = nxt_vld_b | (|wr_be);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_vld_a  <= 1'b0;
      rd_data_b <= '0;
      rd_vld_b  <= 1'b0;
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      if (rd_en_a) begin
        rd_data_a <= ok_a ? nxt_data_a : '0;
        rd_vld_a  <= ok_a && nxt_vld_a;
      end
      if (rd_en_b) begin
        rd_data_b <= ok_b ? nxt_data_b : '0;
        rd_vld_b  <= ok_b && nxt_vld_b;
      end
      wr_err <= wr_en && !wr_ok;
      rd_err <= (rd_en_a && !ok_a) || (rd_en_b && !ok_b);
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: three copies (DEPTH4 bypass, DEPTH4 no bypass, DEPTH3 bypass)
// share one stimulus stream; expectations are queued per step and drained after the edge.
module tb_regfile_bank;

  localparam int W  = 32;
  localparam int IW = 2;
  localparam int NB = 4;

  localparam int D4B = 0;
  localparam int D4N = 10;
  localparam int D3  = 20;
  localparam int F_DA = 0, F_VA = 1, F_DB = 2, F_VB = 3, F_WE = 4, F_RE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [NB-1:0] wr_be;
  logic [W-1:0]  wr_data;
  logic          rd_en_a, rd_en_b;
  logic [IW-1:0] rd_idx_a, rd_idx_b;

  logic [W-1:0] da_4b, db_4b, da_4n, db_4n, da_3, db_3;
  logic va_4b, vb_4b, we_4b, re_4b;
  logic va_4n, vb_4n, we_4n, re_4n;
  logic va_3, vb_3, we_3, re_3;

  always #5 clk = ~clk;

  regfile_bank #(.WIDTH(W), .DEPTH(4), .BYPASS(1), .RST_VAL('0)) u_4b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_idx_a(rd_idx_a), .rd_en_b(rd_en_b), .rd_idx_b(rd_idx_b),
    .rd_data_a(da_4b), .rd_vld_a(va_4b), .rd_data_b(db_4b), .rd_vld_b(vb_4b),
    .wr_err(we_4b), .rd_err(re_4b));

  regfile_bank #(.WIDTH(W), .DEPTH(4), .BYPASS(0), .RST_VAL('0)) u_4n (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_idx_a(rd_idx_a), .rd_en_b(rd_en_b), .rd_idx_b(rd_idx_b),
    .rd_data_a(da_4n), .rd_vld_a(va_4n), .rd_data_b(db_4n), .rd_vld_b(vb_4n),
    .wr_err(we_4n), .rd_err(re_4n));

  regfile_bank #(.WIDTH(W), .DEPTH(3), .BYPASS(1), .RST_VAL('0)) u_3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_idx_a(rd_idx_a), .rd_en_b(rd_en_b), .rd_idx_b(rd_idx_b),
    .rd_data_a(da_3), .rd_vld_a(va_3), .rd_data_b(db_3), .rd_vld_b(vb_3),
    .wr_err(we_3), .rd_err(re_3));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      D4B + F_DA: return da_4b;
      D4B + F_VA: return {31'd0, va_4b};
      D4B + F_DB: return db_4b;
      D4B + F_VB: return {31'd0, vb_4b};
      D4B + F_WE: return {31'd0, we_4b};
      D4B + F_RE: return {31'd0, re_4b};
      D4N + F_DA: return da_4n;
      D4N + F_VA: return {31'd0, va_4n};
      D4N + F_DB: return db_4n;
      D4N + F_VB: return {31'd0, vb_4n};
      D4N + F_WE: return {31'd0, we_4n};
      D4N + F_RE: return {31'd0, re_4n};
      D3  + F_DA: return da_3;
      D3  + F_VA: return {31'd0, va_3};
      D3  + F_DB: return db_3;
      D3  + F_VB: return {31'd0, vb_3};
      D3  + F_WE: return {31'd0, we_3};
      D3  + F_RE: return {31'd0, re_3};
      default:    return 32'hXXXX_XXXX;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic expect_a(input string tag, input int dut, input logic [31:0] d, input logic v);
    expect_val({tag, "_data_a"}, dut + F_DA, d);
    expect_val({tag, "_vld_a"},  dut + F_VA, {31'd0, v});
  endtask

  task automatic expect_b(input string tag, input int dut, input logic [31:0] d, input logic v);
    expect_val({tag, "_data_b"}, dut + F_DB, d);
    expect_val({tag, "_vld_b"},  dut + F_VB, {31'd0, v});
  endtask

  task automatic step();
    sb_item_t it;
    logic [31:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = obs(it.sel);
      total++;
      assert (o === it.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_be = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_idx_a = '0; rd_en_b = 1'b0; rd_idx_b = '0;

    step();
    for (int d = 0; d <= 20; d += 10) begin
      expect_a("rst", d, 32'h0, 1'b0);
      expect_b("rst", d, 32'h0, 1'b0);
      expect_val("rst_wr_err", d + F_WE, 32'd0);
      expect_val("rst_rd_err", d + F_RE, 32'd0);
    end
    step();

    rst = 1'b0;
    rd_en_a = 1'b1; rd_idx_a = 2'd2;
    expect_a("post_rst_rd2", D4B, 32'h0, 1'b0);
    expect_val("post_rst_rd_err", D4B + F_RE, 32'd0);
    step();

    idle();
    wr_en = 1'b1; wr_idx = 2'd1; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
    expect_val("wr1_wr_err", D4B + F_WE, 32'd0);
    step();

    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd1; rd_en_b = 1'b1; rd_idx_b = 2'd0;
    for (int d = 0; d <= 20; d += 10) begin
      expect_a("rb1", d, 32'hDEADBEEF, 1'b1);
      expect_b("rb0", d, 32'h0, 1'b0);
    end
    step();

    rd_idx_a = 2'd2; rd_idx_b = 2'd3;
    expect_a("untouched2", D4B, 32'h0, 1'b0);
    expect_b("untouched3", D4B, 32'h0, 1'b0);
    expect_a("untouched2_nb", D4N, 32'h0, 1'b0);
    step();

    idle();
    wr_en = 1'b1; wr_idx = 2'd3; wr_be = 4'hF; wr_data = 32'h11223344;
    expect_val("wr3_d3_wr_err", D3 + F_WE, 32'd1);
    expect_val("wr3_d4_wr_err", D4B + F_WE, 32'd0);
    step();

    wr_be = 4'b0101; wr_data = 32'hAABBCCDD;
    expect_val("wr3b_d3_wr_err", D3 + F_WE, 32'd1);
    step();

    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd3;
    expect_a("be_merge", D4B, 32'h11BB33DD, 1'b1);
    expect_a("be_merge_nb", D4N, 32'h11BB33DD, 1'b1);
    expect_a("d3_oor_a", D3, 32'h0, 1'b0);
    expect_val("d3_oor_a_rd_err", D3 + F_RE, 32'd1);
    expect_val("d3_wr_err_clear", D3 + F_WE, 32'd0);
    step();

    idle();
    expect_a("hold", D4B, 32'h11BB33DD, 1'b1);
    expect_val("d3_rd_err_one_cycle", D3 + F_RE, 32'd0);
    step();

    wr_en = 1'b1; wr_idx = 2'd2; wr_be = 4'hF; wr_data = 32'h0000CAFE;
    rd_en_a = 1'b1; rd_idx_a = 2'd2;
    expect_a("bypass_on", D4B, 32'h0000CAFE, 1'b1);
    expect_a("bypass_off", D4N, 32'h0, 1'b0);
    expect_a("bypass_on_d3", D3, 32'h0000CAFE, 1'b1);
    step();

    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd2;
    expect_a("after_bypass_off", D4N, 32'h0000CAFE, 1'b1);
    step();

    idle();
    wr_en = 1'b1; wr_idx = 2'd3; wr_be = 4'hF; wr_data = 32'h12345678;
    rd_en_b = 1'b1; rd_idx_b = 2'd3;
    expect_b("d3_oor_b", D3, 32'h0, 1'b0);
    expect_val("d3_oor_b_rd_err", D3 + F_RE, 32'd1);
    expect_val("d3_oor_b_wr_err", D3 + F_WE, 32'd1);
    expect_b("bypass_b", D4B, 32'h12345678, 1'b1);
    expect_b("no_bypass_b", D4N, 32'h11BB33DD, 1'b1);
    step();

    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd0; rd_en_b = 1'b1; rd_idx_b = 2'd1;
    expect_val("d3_rd_err_drop", D3 + F_RE, 32'd0);
    expect_val("d3_wr_err_drop", D3 + F_WE, 32'd0);
    expect_a("d3_ent0", D3, 32'h0, 1'b0);
    expect_b("d3_ent1", D3, 32'hDEADBEEF, 1'b1);
    step();

    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd2;
    expect_a("d3_ent2", D3, 32'h0000CAFE, 1'b1);
    step();

    idle();
    wr_en = 1'b1; wr_idx = 2'd0; wr_be = 4'h0; wr_data = 32'hFFFFFFFF;
    step();

    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd0;
    expect_a("be_zero", D4B, 32'h0, 1'b0);
    step();

    rd_idx_a = 2'd1; rd_en_b = 1'b1; rd_idx_b = 2'd1;
    expect_a("same_idx", D4B, 32'hDEADBEEF, 1'b1);
    expect_b("same_idx", D4B, 32'hDEADBEEF, 1'b1);
    step();

    idle();
    rst = 1'b1;
    wr_en = 1'b1; wr_idx = 2'd0; wr_be = 4'hF; wr_data = 32'h5;
    rd_en_a = 1'b1; rd_idx_a = 2'd1;
    expect_a("mid_rst", D4B, 32'h0, 1'b0);
    expect_b("mid_rst", D4B, 32'h0, 1'b0);
    expect_val("mid_rst_wr_err", D4B + F_WE, 32'd0);
    step();

    rst = 1'b0;
    idle();
    rd_en_a = 1'b1; rd_idx_a = 2'd0; rd_en_b = 1'b1; rd_idx_b = 2'd1;
    expect_a("post_mid_rst0", D4B, 32'h0, 1'b0);
    expect_b("post_mid_rst1", D4B, 32'h0, 1'b0);
    step();

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
